// File: rtl/recurrence_machine_if.sv
// Bundles the run-control, ALU/regfile control and term-stream signals of
// recurrence_machine. The slave view belongs to the sequencer itself; the
// master view belongs to whatever drives start and supplies the ALU result.
interface recurrence_machine_if #(
  parameter int WIDTH      = 16,
  parameter int REG_ADDR_W = 3
);
  // Run request
  logic                  start;
  logic [1:0]            mode;
  logic [7:0]            n_terms;

  // ALU / register-file path
  logic [WIDTH-1:0]      alu_bus;
  logic [4:0]            flags;
  logic [REG_ADDR_W-1:0] a_reg;
  logic [REG_ADDR_W-1:0] b_reg;
  logic [REG_ADDR_W-1:0] dest_reg;
  logic [WIDTH-1:0]      immediate;
  logic                  immediate_p;
  logic [7:0]            alu_op;

  // Term stream and status
  logic [WIDTH-1:0]      term;
  logic                  term_valid;
  logic [7:0]            term_idx;
  logic                  busy;
  logic                  done;
  logic                  overflow;

  modport master (
    output start, mode, n_terms, alu_bus, flags,
    input  a_reg, b_reg, dest_reg, immediate, immediate_p, alu_op,
    input  term, term_valid, term_idx, busy, done, overflow
  );

  modport slave (
    input  start, mode, n_terms, alu_bus, flags,
    output a_reg, b_reg, dest_reg, immediate, immediate_p, alu_op,
    output term, term_valid, term_idx, busy, done, overflow
  );
endinterface

// File: rtl/recurrence_machine.sv
// Sequencer that drives an external ALU/register file to generate
// Fibonacci, Lucas or doubling sequences, one term per cycle.
// R0/R1 hold the two most recent terms; the scratch register absorbs
// the writes that the regfile performs in cycles with nothing to store.
module recurrence_machine #(
  parameter int          WIDTH       = 16,
  parameter int          REG_ADDR_W  = 3,
  parameter logic [7:0]  ALU_ADD     = 8'h05,
  parameter logic [7:0]  ALU_MOVI    = 8'h0D,
  parameter int          SCRATCH_REG = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  recurrence_machine_if.slave  bus
);

  localparam logic [REG_ADDR_W-1:0] R0      = '0;
  localparam logic [REG_ADDR_W-1:0] R1      = REG_ADDR_W'(1);
  localparam logic [REG_ADDR_W-1:0] SCRATCH = REG_ADDR_W'(SCRATCH_REG);

  localparam logic [1:0] MODE_FIB    = 2'd0;
  localparam logic [1:0] MODE_LUCAS  = 2'd1;
  localparam logic [1:0] MODE_DOUBLE = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    SEED0,
    SEED1,
    STEP,
    DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [1:0]      mode_reg, mode_next;
  logic [7:0]      n_terms_reg, n_terms_next;
  logic [7:0]      idx_reg, idx_next;
  logic            overflow_reg, overflow_next;
  // Selects R1 (1) or R0 (0) as the destination of the next additive step
  logic            dest_sel_reg, dest_sel_next;

  // Combinational output values, routed onto the interface below
  logic [REG_ADDR_W-1:0] a_sel, b_sel, dest_sel;
  logic [WIDTH-1:0]      imm_val;
  logic                  imm_p;
  logic [7:0]            op_val;
  logic [WIDTH-1:0]      term_val;
  logic                  term_valid_val;
  logic                  busy_val;
  logic                  done_val;

  logic carry;
  logic last_term;
  logic unused_flags;

  assign carry        = bus.flags[0];
  // Only the carry flag participates in sequencing
  assign unused_flags = ^bus.flags[4:1];
  // The term emitted this cycle is the final one requested
  assign last_term    = ((idx_reg + 8'd1) == n_terms_reg);

  // Next-state and output decode; idle-style ALU control is the default
  always_comb begin
    state_next     = state_reg;
    mode_next      = mode_reg;
    n_terms_next   = n_terms_reg;
    idx_next       = idx_reg;
    overflow_next  = overflow_reg;
    dest_sel_next  = dest_sel_reg;

    a_sel          = R0;
    b_sel          = R0;
    dest_sel       = SCRATCH;
    imm_val        = '0;
    imm_p          = 1'b1;
    op_val         = ALU_MOVI;
    term_val       = '0;
    term_valid_val = 1'b0;
    busy_val       = 1'b0;
    done_val       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.start && (bus.mode != MODE_RSVD)) begin
          mode_next     = bus.mode;
          n_terms_next  = bus.n_terms;
          idx_next      = '0;
          overflow_next = 1'b0;
          dest_sel_next = 1'b0;
          state_next    = (bus.n_terms == 8'd0) ? DONE : SEED0;
        end
      end

      SEED0: begin
        busy_val       = 1'b1;
        dest_sel       = R0;
        case (mode_reg)
          MODE_FIB:   imm_val = WIDTH'(0);
          MODE_LUCAS: imm_val = WIDTH'(2);
          default:    imm_val = WIDTH'(1);
        endcase
        term_val       = bus.alu_bus;
        term_valid_val = 1'b1;
        idx_next       = idx_reg + 8'd1;
        if (last_term) begin
          state_next = DONE;
        end else if (mode_reg == MODE_DOUBLE) begin
          state_next = STEP;
        end else begin
          state_next = SEED1;
        end
      end

      SEED1: begin
        busy_val       = 1'b1;
        dest_sel       = R1;
        imm_val        = WIDTH'(1);
        term_val       = bus.alu_bus;
        term_valid_val = 1'b1;
        idx_next       = idx_reg + 8'd1;
        state_next     = last_term ? DONE : STEP;
      end

      STEP: begin
        busy_val = 1'b1;
        op_val   = ALU_ADD;
        imm_p    = 1'b0;
        a_sel    = R0;
        term_val = bus.alu_bus;
        if (mode_reg == MODE_DOUBLE) begin
          b_sel    = R0;
          dest_sel = R0;
        end else begin
          b_sel    = R1;
          dest_sel = dest_sel_reg ? R1 : R0;
        end
        if (carry) begin
          // Divert the truncated sum so R0/R1 keep the last good pair
          dest_sel      = SCRATCH;
          overflow_next = 1'b1;
          state_next    = DONE;
        end else begin
          term_valid_val = 1'b1;
          idx_next       = idx_reg + 8'd1;
          dest_sel_next  = ~dest_sel_reg;
          state_next     = last_term ? DONE : STEP;
        end
      end

      DONE: begin
        done_val   = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and run-context registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      mode_reg     <= MODE_FIB;
      n_terms_reg  <= '0;
      idx_reg      <= '0;
      overflow_reg <= 1'b0;
      dest_sel_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      mode_reg     <= mode_next;
      n_terms_reg  <= n_terms_next;
      idx_reg      <= idx_next;
      overflow_reg <= overflow_next;
      dest_sel_reg <= dest_sel_next;
    end
  end

  assign bus.a_reg       = a_sel;
  assign bus.b_reg       = b_sel;
  assign bus.dest_reg    = dest_sel;
  assign bus.immediate   = imm_val;
  assign bus.immediate_p = imm_p;
  assign bus.alu_op      = op_val;
  assign bus.term        = term_val;
  assign bus.term_valid  = term_valid_val;
  assign bus.term_idx    = idx_reg;
  assign bus.busy        = busy_val;
  assign bus.done        = done_val;
  assign bus.overflow    = overflow_reg;

endmodule

// File: tb/tb_recurrence_machine.sv
// Directed bench for recurrence_machine with a behavioural ALU/regfile.
module tb_recurrence_machine;

  localparam int WIDTH      = 16;
  localparam int REG_ADDR_W = 3;

  logic clk;
  logic reset;

  recurrence_machine_if #(.WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W)) bus ();

  recurrence_machine #(
    .WIDTH       (WIDTH),
    .REG_ADDR_W  (REG_ADDR_W),
    .ALU_ADD     (8'h05),
    .ALU_MOVI    (8'h0D),
    .SCRATCH_REG (7)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural ALU + 8-entry register file (writes dest_reg every cycle)
  logic [WIDTH-1:0] regs [0:7];
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH:0]   sum;

  always_comb begin
    operand_b   = bus.immediate_p ? bus.immediate : regs[bus.b_reg];
    sum         = {1'b0, regs[bus.a_reg]} + {1'b0, operand_b};
    bus.alu_bus = '0;
    bus.flags   = '0;
    if (bus.alu_op == 8'h0D) begin
      bus.alu_bus = bus.immediate;
    end else if (bus.alu_op == 8'h05) begin
      bus.alu_bus = sum[WIDTH-1:0];
      bus.flags   = {4'b0000, sum[WIDTH]};
    end
  end

  always @(posedge clk) regs[bus.dest_reg] <= bus.alu_bus;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int exp_terms[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch a run and follow it term by term through DONE back to IDLE
  task automatic run_seq(input logic [1:0] m, input logic [7:0] n,
                         input bit exp_ovf, input bit poke);
    int nexp;
    int busy_cycles;
    nexp        = exp_terms.size();
    busy_cycles = 0;
    chk("idle_busy", bus.busy, 0);
    bus.start   = 1'b1;
    bus.mode    = m;
    bus.n_terms = n;
    tick();
    bus.start   = 1'b0;
    for (int i = 0; i < nexp; i++) begin
      chk("term_valid", bus.term_valid, 1);
      chk("term", bus.term, exp_terms[i]);
      chk("term_idx", bus.term_idx, i);
      chk("run_busy", bus.busy, 1);
      chk("run_done", bus.done, 0);
      if (bus.busy) busy_cycles++;
      if (poke && i == 3) begin
        bus.start   = 1'b1;
        bus.mode    = 2'd1;
        bus.n_terms = 8'd2;
      end
      tick();
      bus.start = 1'b0;
    end
    if (exp_ovf) begin
      chk("ovf_term_valid", bus.term_valid, 0);
      chk("ovf_busy", bus.busy, 1);
      chk("ovf_dest_scratch", bus.dest_reg, 7);
      if (bus.busy) busy_cycles++;
      tick();
    end
    chk("done_pulse", bus.done, 1);
    chk("done_busy", bus.busy, 0);
    chk("done_term_valid", bus.term_valid, 0);
    chk("done_overflow", bus.overflow, exp_ovf);
    chk("done_dest", bus.dest_reg, 7);
    chk("done_alu_op", bus.alu_op, 8'h0D);
    tick();
    chk("after_done", bus.done, 0);
    chk("after_busy", bus.busy, 0);
    chk("after_overflow", bus.overflow, exp_ovf);
    chk("busy_cycles", busy_cycles, nexp + (exp_ovf ? 1 : 0));
  endtask

  initial begin
    reset       = 1'b0;
    bus.start   = 1'b0;
    bus.mode    = 2'd0;
    bus.n_terms = 8'd0;
    tick();
    tick();

    // Reset state
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_term_valid", bus.term_valid, 0);
    chk("rst_term", bus.term, 0);
    chk("rst_term_idx", bus.term_idx, 0);
    chk("rst_dest", bus.dest_reg, 7);
    chk("rst_alu_op", bus.alu_op, 8'h0D);
    chk("rst_imm", bus.immediate, 0);
    chk("rst_imm_p", bus.immediate_p, 1);
    reset = 1'b1;
    tick();

    // Fibonacci, with a start pulse injected mid-run
    exp_terms = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
    run_seq(2'd0, 8'd10, 1'b0, 1'b1);
    $display("fib10: checks=%0d errors=%0d", n_checks, n_errors);

    // Lucas
    exp_terms = '{2, 1, 3, 4, 7};
    run_seq(2'd1, 8'd5, 1'b0, 1'b0);
    $display("lucas5: checks=%0d errors=%0d", n_checks, n_errors);

    // Doubling until carry
    exp_terms = {};
    for (int i = 0; i < 16; i++) exp_terms.push_back(1 << i);
    run_seq(2'd2, 8'd20, 1'b1, 1'b0);
    $display("double20: checks=%0d errors=%0d", n_checks, n_errors);

    // Reserved mode is ignored; overflow from the previous run persists
    bus.start = 1'b1;
    bus.mode  = 2'd3;
    bus.n_terms = 8'd5;
    tick();
    bus.start = 1'b0;
    chk("mode3_busy", bus.busy, 0);
    chk("mode3_done", bus.done, 0);
    chk("mode3_overflow", bus.overflow, 1);
    tick();
    chk("mode3_busy2", bus.busy, 0);
    chk("mode3_valid2", bus.term_valid, 0);
    $display("mode3: checks=%0d errors=%0d", n_checks, n_errors);

    // n_terms = 0 goes straight to DONE
    bus.start   = 1'b1;
    bus.mode    = 2'd0;
    bus.n_terms = 8'd0;
    tick();
    bus.start = 1'b0;
    chk("n0_done", bus.done, 1);
    chk("n0_valid", bus.term_valid, 0);
    chk("n0_busy", bus.busy, 0);
    tick();
    chk("n0_done_clear", bus.done, 0);
    chk("n0_valid2", bus.term_valid, 0);
    $display("n0: checks=%0d errors=%0d", n_checks, n_errors);

    // n_terms = 1
    exp_terms = '{0};
    run_seq(2'd0, 8'd1, 1'b0, 1'b0);
    $display("n1: checks=%0d errors=%0d", n_checks, n_errors);

    // Fibonacci overflow: F(25) carries
    exp_terms = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377,
                  610, 987, 1597, 2584, 4181, 6765, 10946, 17711, 28657, 46368};
    run_seq(2'd0, 8'd40, 1'b1, 1'b0);
    chk("fib_ovf_regmax", (regs[0] > regs[1]) ? regs[0] : regs[1], 46368);
    chk("fib_ovf_regmin", (regs[0] > regs[1]) ? regs[1] : regs[0], 28657);
    $display("fib40: checks=%0d errors=%0d", n_checks, n_errors);

    // Reset mid-run at idx 4
    bus.start   = 1'b1;
    bus.mode    = 2'd0;
    bus.n_terms = 8'd10;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("pre_rst_idx", bus.term_idx, 4);
    chk("pre_rst_term", bus.term, 3);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_overflow", bus.overflow, 0);
    chk("mid_rst_valid", bus.term_valid, 0);
    chk("mid_rst_term", bus.term, 0);
    chk("mid_rst_idx", bus.term_idx, 0);
    tick();
    chk("post_rst_busy", bus.busy, 0);
    $display("midrst: checks=%0d errors=%0d", n_checks, n_errors);

    // Clean restart after reset
    exp_terms = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
    run_seq(2'd0, 8'd10, 1'b0, 1'b0);
    $display("restart: checks=%0d errors=%0d", n_checks, n_errors);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/recurrence_machine.md
RECURRENCE_MACHINE -- requirements
Module: recurrence_machine

Interface
REQ-001 Parameter WIDTH, 16, datapath and term width in bits.
REQ-002 Parameter REG_ADDR_W, 3, register-file address width.
REQ-003 Parameter ALU_ADD, 8'h05, alu_op code for a_reg + b_reg (or a_reg + immediate when immediate_p=1).
REQ-004 Parameter ALU_MOVI, 8'h0D, alu_op code for result = immediate.
REQ-005 Parameter SCRATCH_REG, 7, register written while idle or done; never holds state.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 reset  in  1  synchronous, active-low (0 = reset, sampled on clk rising edge).
REQ-008 start  in  1  run request, sampled in IDLE only.
REQ-009 mode  in  2  0 Fibonacci (seeds 0,1); 1 Lucas (seeds 2,1); 2 doubling (seed 1); 3 reserved.
REQ-010 n_terms  in  8  number of terms to emit, including seeds.
REQ-011 alu_bus  in  WIDTH  combinational ALU result from alu_regfile.
REQ-012 flags  in  5  ALU flags; flags[0] is carry-out.
REQ-013 a_reg, b_reg, dest_reg  out  REG_ADDR_W each  regfile operand/destination select.
REQ-014 immediate  out  WIDTH; immediate_p  out  1; alu_op  out  8  ALU control.
REQ-015 term  out  WIDTH; term_valid  out  1; term_idx  out  8  emitted term and its 0-based index.
REQ-016 busy  out  1; done  out  1; overflow  out  1  status.

Function
REQ-017 The FSM SHALL have states IDLE, SEED0, SEED1, STEP, DONE; every state lasts exactly one cycle, except IDLE and STEP, which persist as specified below.
REQ-018 In IDLE and DONE, outputs SHALL be dest_reg=SCRATCH_REG, alu_op=ALU_MOVI, immediate=0, immediate_p=1, term_valid=0.
REQ-019 IDLE: start=1 with mode!=3 and n_terms>=1 SHALL latch mode and n_terms, clear overflow and term_idx, and go to SEED0; with n_terms=0 it SHALL go directly to DONE; mode=3 SHALL be ignored and the FSM SHALL remain in IDLE.
REQ-020 SEED0 SHALL drive ALU_MOVI, immediate_p=1, dest=R0, immediate = 0 (mode 0), 2 (mode 1), or 1 (mode 2).
REQ-021 SEED1 (modes 0/1 only) SHALL drive ALU_MOVI, dest=R1, immediate=1.
REQ-022 STEP, modes 0/1, SHALL drive ALU_ADD, immediate_p=0, a_reg=R0, b_reg=R1, dest alternating R0, R1, R0, … starting with R0 on the first STEP.
REQ-023 STEP, mode 2, SHALL drive ALU_ADD, a_reg=b_reg=dest_reg=R0.
REQ-024 In SEED0, SEED1, and STEP, term SHALL equal alu_bus and term_idx SHALL equal the count of terms already emitted; term_valid SHALL be 1 unless overflow is detected in that cycle.
REQ-025 Transitions: after the term with index n_terms-1 is emitted, the FSM SHALL go to DONE; otherwise SEED0->SEED1 (modes 0/1), SEED0->STEP (mode 2), SEED1->STEP, and STEP->STEP.
REQ-026 In STEP, flags[0]=1 SHALL suppress term_valid for that cycle, force dest_reg=SCRATCH_REG (preserving R0/R1), set overflow, and go to DONE.
REQ-027 overflow SHALL stay set through DONE and IDLE until the next accepted start or reset.
REQ-028 DONE SHALL assert done=1 for exactly one cycle and then return to IDLE.
REQ-029 busy SHALL be 1 exactly in SEED0, SEED1, and STEP.
REQ-030 start asserted while not in IDLE SHALL be ignored and SHALL NOT be queued.
REQ-031 Latency: for start accepted at edge E, the first term_valid SHALL occur in the cycle after E; terms SHALL follow on consecutive cycles with no gaps; done SHALL occur in the cycle after the last term.

Reset
REQ-032 reset=0 at a clk edge SHALL force IDLE from any state, including mid-run.
REQ-033 During and after reset, done, busy, overflow, term_valid, term, and term_idx SHALL be 0, with IDLE control outputs per REQ-018.
REQ-034 After reset, no regfile state SHALL be assumed; every run reseeds R0/R1.

Verification
REQ-035 Fibonacci: mode 0, n_terms=10 -> terms 0,1,1,2,3,5,8,13,21,34 with idx 0..9 on 10 consecutive cycles; done 1 cycle later; overflow=0.
REQ-036 Lucas: mode 1, n_terms=5 -> 2,1,3,4,7; done once; busy high exactly 5 cycles.
REQ-037 Doubling: WIDTH=16, mode 2, n_terms=20 -> 1,2,…,32768 (16 terms, idx 0..15); carry on the 17th step -> no term_valid, overflow=1, done.
REQ-038 Fibonacci overflow: WIDTH=16, mode 0, n_terms=40 -> terms F(0)..F(24)=46368 emitted; F(25) carries -> overflow=1, done; R0/R1 retain F(23)/F(24).
REQ-039 Boundaries: n_terms=0 -> done the next cycle with no term_valid; n_terms=1 -> single term 0 then done; mode=3 -> stays IDLE, busy=0.
REQ-040 Interference: start pulsed mid-run -> sequence unchanged; reset=0 at idx 4 -> IDLE with all status outputs 0 next cycle; a new start then restarts cleanly from idx 0.
